// File: rtl/key_step_conditioner.sv
// Pushbutton conditioner: synchronizes and debounces an active-low key, then
// emits one-clock press/release pulses and a step pulse with hold-to-repeat.
module key_step_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_RATE     = 10_000_000,
    parameter int unsigned DB_W            = 20,
    parameter int unsigned TMR_W           = 25
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic step,
    output logic repeating
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    logic             sync1;
    logic             sync2;
    logic             raw;
    logic [DB_W-1:0]  db_cnt;
    logic             accept;
    logic             press_evt;
    logic             release_evt;
    logic             tick;
    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;

    assign raw         = ~sync2;
    assign accept      = (raw != level) && (db_cnt == DB_LAST);
    assign press_evt   = accept & raw;
    assign release_evt = accept & ~raw;
    assign repeating   = (state == REPEAT);

    // Synchronizer flops reset to the released level so a held key reads as a new press.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (raw != level) begin
            if (db_cnt == DB_LAST) begin
                level  <= raw;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Release is handled first so it suppresses a coincident repeat tick.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        tick      = 1'b0;
        if (release_evt) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_evt) begin
                        state_nxt = HOLD;
                        tmr_nxt   = '0;
                    end
                end
                HOLD: begin
                    if (repeat_en) begin
                        if (tmr == DELAY_LAST) begin
                            tick      = 1'b1;
                            state_nxt = REPEAT;
                            tmr_nxt   = '0;
                        end else begin
                            tmr_nxt = tmr + TMR_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!repeat_en) begin
                        state_nxt = HOLD;
                        tmr_nxt   = '0;
                    end else if (tmr == RATE_LAST) begin
                        tick    = 1'b1;
                        tmr_nxt = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            tmr           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step          <= 1'b0;
        end else begin
            state         <= state_nxt;
            tmr           <= tmr_nxt;
            press_pulse   <= press_evt;
            release_pulse <= release_evt;
            step          <= press_evt | tick;
        end
    end

endmodule

// File: tb/tb_key_step_conditioner.sv
// Scoreboard bench for key_step_conditioner: expected pulse cycles are queued
// when the key is driven and compared every cycle against the DUT pulses.
module tb_key_step_conditioner;

    logic clock;
    logic reset;
    logic key_n;
    logic repeat_en;
    logic level;
    logic press_pulse;
    logic release_pulse;
    logic step;
    logic repeating;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_press[$];
    int exp_release[$];
    int exp_step[$];

    key_step_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE(3),
        .DB_W(3),
        .TMR_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_n(key_n),
        .repeat_en(repeat_en),
        .level(level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .step(step),
        .repeating(repeating)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, expv);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // Every cycle each pulse must be high exactly when its queue head names this cycle.
    always @(negedge clock) begin : monitor
        logic ep, er, es;
        ep = (exp_press.size() > 0) && (exp_press[0] == cyc);
        er = (exp_release.size() > 0) && (exp_release[0] == cyc);
        es = (exp_step.size() > 0) && (exp_step[0] == cyc);
        if (ep) void'(exp_press.pop_front());
        if (er) void'(exp_release.pop_front());
        if (es) void'(exp_step.pop_front());
        check("press_pulse", press_pulse, ep);
        check("release_pulse", release_pulse, er);
        check("step", step, es);
    end

    initial begin
        #100000;
        $display("FAIL timeout: got cyc %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int t0;
        int r;
        reset     = 1'b1;
        key_n     = 1'b0;
        repeat_en = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_level", level, 0);
        check("rst_press", press_pulse, 0);
        check("rst_release", release_pulse, 0);
        check("rst_step", step, 0);
        check("rst_repeating", repeating, 0);

        // key held through reset: fresh press 2+4 clocks after release
        c = cyc;
        reset = 1'b0;
        exp_press.push_back(c + 6);
        exp_step.push_back(c + 6);
        wait_to(c + 5);
        check("held_level_pre", level, 0);
        wait_to(c + 6);
        check("held_level", level, 1);
        wait_to(c + 12);
        key_n = 1'b1;
        c = cyc;
        exp_release.push_back(c + 6);
        wait_to(c + 10);
        check("held_level_rel", level, 0);

        // bounce: 3 low, 1 high, 3 low
        c = cyc;
        key_n = 1'b0;
        wait_to(c + 3);
        key_n = 1'b1;
        wait_to(c + 4);
        key_n = 1'b0;
        wait_to(c + 7);
        key_n = 1'b1;
        wait_to(c + 14);
        check("bounce_db_cnt", dut.db_cnt, 0);
        check("bounce_level", level, 0);

        // clean tap of 20 clocks, no repeat
        c = cyc;
        key_n = 1'b0;
        exp_press.push_back(c + 6);
        exp_step.push_back(c + 6);
        exp_release.push_back(c + 26);
        wait_to(c + 6);
        check("tap_level_rise", level, 1);
        wait_to(c + 20);
        key_n = 1'b1;
        wait_to(c + 25);
        check("tap_level_hold", level, 1);
        check("tap_repeating", repeating, 0);
        wait_to(c + 26);
        check("tap_level_fall", level, 0);
        wait_to(c + 30);

        // hold 40 clocks with repeat; the release lands on a repeat tick
        c = cyc;
        key_n = 1'b0;
        repeat_en = 1'b1;
        t0 = c + 6;
        exp_press.push_back(t0);
        exp_step.push_back(t0);
        for (int k = 0; k < 10; k++) exp_step.push_back(t0 + 10 + 3 * k);
        exp_release.push_back(t0 + 40);
        wait_to(t0 + 9);
        check("rep_repeating_pre", repeating, 0);
        wait_to(t0 + 10);
        check("rep_repeating_on", repeating, 1);
        wait_to(c + 40);
        key_n = 1'b1;
        wait_to(t0 + 39);
        check("rep_repeating_late", repeating, 1);
        wait_to(t0 + 40);
        check("rep_release_repeating", repeating, 0);
        check("rep_release_state", dut.state, 0);
        wait_to(t0 + 45);

        // hold with repeat disabled, enable mid-hold, then drop in REPEAT
        repeat_en = 1'b0;
        c = cyc;
        key_n = 1'b0;
        t0 = c + 6;
        exp_press.push_back(t0);
        exp_step.push_back(t0);
        wait_to(c + 15);
        r = cyc;
        repeat_en = 1'b1;
        exp_step.push_back(r + 10);
        exp_step.push_back(r + 13);
        wait_to(r + 9);
        check("en_repeating_pre", repeating, 0);
        wait_to(r + 10);
        check("en_repeating_on", repeating, 1);
        wait_to(r + 15);
        repeat_en = 1'b0;
        wait_to(r + 16);
        check("drop_repeating", repeating, 0);
        wait_to(r + 28);
        check("drop_level", level, 1);
        c = cyc;
        key_n = 1'b1;
        exp_release.push_back(c + 6);
        wait_to(c + 8);

        // reset while in REPEAT
        c = cyc;
        key_n = 1'b0;
        repeat_en = 1'b1;
        t0 = c + 6;
        exp_press.push_back(t0);
        exp_step.push_back(t0);
        exp_step.push_back(t0 + 10);
        wait_to(t0 + 12);
        check("mid_repeating", repeating, 1);
        reset = 1'b1;
        key_n = 1'b1;
        wait_to(t0 + 13);
        check("mid_rst_level", level, 0);
        check("mid_rst_press", press_pulse, 0);
        check("mid_rst_release", release_pulse, 0);
        check("mid_rst_step", step, 0);
        check("mid_rst_repeating", repeating, 0);
        wait_to(t0 + 14);
        reset = 1'b0;
        wait_to(t0 + 24);
        check("post_rst_level", level, 0);

        check("q_press_left", exp_press.size(), 0);
        check("q_release_left", exp_release.size(), 0);
        check("q_step_left", exp_step.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
